modport_rcvr_side: RTL and testbench
====================================

# modport_rcvr_side

Receive-side monitor of the MAC-to-PHY lane in the PCIe PHY model. It observes the 8-bit symbol stream (with K flag) driven by the MAC into a 16-symbol sliding window and classifies the window as SKP, TS1, TS2 or none. It captures the TS fields and counts consecutive TS1/TS2 ordered sets. It also raises the LTSSM configuration handshake flags and counts idle data symbols.

## Interface
- MAX_TS_LEN, 16: window depth in symbols; only 16 supported.
- CTR_W, 16: width of the TS and idle counters.

- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- txdata  in  8  symbol from MAC
- txdatak  in  1  1 = txdata is a K symbol
- en_n  in  1  symbol valid, active-low
- curr_ltssm_state  in  ltssm_state_t (4)  current LTSSM state
- os_type  out  os_type_t (2)  NONE=0, SKP=1, TS1=2, TS2=3; classification of the current window
- ts1_ctr, ts2_ctr  out  CTR_W  consecutive TS1 / TS2 count
- ts1_linkn, ts1_lanen, ts1_nfts, ts1_dri, ts1_tc  out  8 each  fields of last TS1
- ts2_linkn, ts2_lanen, ts2_nfts, ts2_dri, ts2_tc  out  8 each  fields of last TS2
- link_proposed, lane_proposed, config_complete  out  1  handshake flags
- idle_ctr  out  CTR_W  consecutive idle data symbols

## Operation
- Window entries are 9 bits, {k, data}. q[0] is the oldest entry.
- Shift rule: on each clk with en_n=0, q[i] <= q[i+1] and q[15] <= {txdatak, txdata}. When en_n=1 the window holds.
- Classification is combinational on the registered window. Priority order is SKP, then TS1, then TS2, then NONE.
  - SKP: q[0]=K COM, q[1]=K SKP, q[2]=K SKP.
  - TS1: q[0]=K COM and q[6..15] all D TS1ID.
  - TS2: q[0]=K COM and q[6..15] all D TS2ID.
- TS field mapping: q[1]=link number, q[2]=lane number, q[3]=N_FTS, q[4]=data rate identifier, q[5]=training control. A PAD match requires k=1.
- Detection event: fires on the clock edge where the shifted-in next window classifies as TS1 or TS2, evaluated only when en_n=0. A held window never re-counts.
- On a TS1 event:
  - capture the ts1_* fields;
  - ts1_ctr increments, saturating at all ones;
  - ts2_ctr clears.
- A TS2 event is symmetric: capture ts2_*, increment ts2_ctr, clear ts1_ctr.
- SKP windows affect no counter.
- link_proposed = (os_type==TS1) && q[1] != PAD && state==CONFIG_LINKWIDTH_START.
- lane_proposed = (os_type==TS1) && q[2] != PAD && state==CONFIG_LINKWIDTH_ACCEPT.
- config_complete = (os_type==TS2) && q[1] != PAD && q[2] != PAD && state==CONFIG_LANENUM_ACCEPT.
- idle_ctr:
  - when state==CONFIG_IDLE or L0, it increments (saturating) on each en_n=0 symbol equal to D 8'h00;
  - any other valid symbol clears it;
  - it holds when en_n=1;
  - it clears in any other state.
- State change (curr_ltssm_state differs from its registered copy):
  - window flushes to all zero and the incoming symbol is discarded;
  - ts1_ctr, ts2_ctr and idle_ctr clear;
  - TS field registers hold.

## Timing
- Reset values: all outputs 0, os_type=NONE, window all zero, registered state copy = DETECT_QUIET.
- Latency:
  - counters and fields update on the edge that captures the 16th TS symbol;
  - os_type and the flags become valid in the same cycle after that edge;
  - they drop on the next valid symbol.
- A state change and a detection on the same edge: the flush and clear win, so no count occurs.
- A reset mid-ordered-set discards the partial window.
- Back-to-back TS sets with no gap count once per 16 valid symbols.

## Structure
- Package ozphy_pkg holds:
  - ltssm_state_t (4-bit): DETECT_QUIET=0, DETECT_ACTIVE=1, POLLING_ACTIVE=2, POLLING_CONFIG=3, CONFIG_LINKWIDTH_START=4, CONFIG_LINKWIDTH_ACCEPT=5, CONFIG_LANENUM_WAIT=6, CONFIG_LANENUM_ACCEPT=7, CONFIG_COMPLETE=8, CONFIG_IDLE=9, L0=10;
  - os_type_t;
  - symbol constants COM=8'hBC, SKP=8'h1C, PAD=8'hF7, TS1ID=8'h4A, TS2ID=8'h45.
- One natural sub-module, os_window: the shift window plus the classifier.

## Test plan
- Reset asserted mid-stream -> all outputs 0 and os_type=NONE immediately.
- In CONFIG_LINKWIDTH_START, send TS1 with link=8'h01, lane=PAD, nfts=8'h20, dri=8'h02, tc=0 -> ts1_ctr=1, ts1_linkn=8'h01, ts1_nfts=8'h20, link_proposed=1 for one valid-symbol period.
- Send 8 back-to-back TS1 in CONFIG_LINKWIDTH_ACCEPT with lane=8'h00, with en_n toggling high inside sets -> ts1_ctr=8 and lane_proposed pulses each set; then one TS2 -> ts1_ctr=0, ts2_ctr=1.
- In CONFIG_LANENUM_ACCEPT, send TS2 with link=1, lane=0 -> config_complete=1; with link=PAD -> config_complete=0.
- Send COM SKP SKP SKP between TS1 sets -> os_type=SKP and counters unchanged.
- Change state to CONFIG_IDLE, then send 20 D 8'h00 -> counters clear on the state change and idle_ctr=20; one non-zero symbol -> idle_ctr=0.

Source files
------------

// File: rtl/ozphy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ozphy_pkg
// Description : Shared types and constants for the PCIe PHY model lane
//               monitors: LTSSM state encoding, ordered-set classification,
//               8b/10b special symbols and the window classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package ozphy_pkg;

    // Window geometry: 16 symbols of {k, data}
    localparam int WIN_DEPTH = 16;
    localparam int SYM_W     = 9;

    typedef enum logic [3:0] {
        DETECT_QUIET            = 4'd0,
        DETECT_ACTIVE           = 4'd1,
        POLLING_ACTIVE          = 4'd2,
        POLLING_CONFIG          = 4'd3,
        CONFIG_LINKWIDTH_START  = 4'd4,
        CONFIG_LINKWIDTH_ACCEPT = 4'd5,
        CONFIG_LANENUM_WAIT     = 4'd6,
        CONFIG_LANENUM_ACCEPT   = 4'd7,
        CONFIG_COMPLETE         = 4'd8,
        CONFIG_IDLE             = 4'd9,
        L0                      = 4'd10
    } ltssm_state_t;

    typedef enum logic [1:0] {
        OS_NONE = 2'd0,
        OS_SKP  = 2'd1,
        OS_TS1  = 2'd2,
        OS_TS2  = 2'd3
    } os_type_t;

    // Special symbols
    localparam logic [7:0] COM       = 8'hBC;
    localparam logic [7:0] SKP       = 8'h1C;
    localparam logic [7:0] PAD       = 8'hF7;
    localparam logic [7:0] TS1ID     = 8'h4A;
    localparam logic [7:0] TS2ID     = 8'h45;
    localparam logic [7:0] IDLE_DATA = 8'h00;

    typedef logic [SYM_W-1:0]                 sym_t;
    typedef logic [WIN_DEPTH-1:0][SYM_W-1:0]  window_t;

    // Training-set payload bytes following the COM symbol
    typedef struct packed {
        logic [7:0] linkn;
        logic [7:0] lanen;
        logic [7:0] nfts;
        logic [7:0] dri;
        logic [7:0] tc;
    } ts_fields_t;

    function automatic sym_t k_sym(input logic [7:0] d);
        return {1'b1, d};
    endfunction

    function automatic sym_t d_sym(input logic [7:0] d);
        return {1'b0, d};
    endfunction

    // Classify a window; index 0 is the oldest symbol.
    // Priority: SKP, TS1, TS2, NONE.
    function automatic os_type_t classify(input window_t w);
        logic     is_com;
        logic     is_skp;
        logic     ts1_ids;
        logic     ts2_ids;
        os_type_t result;
        is_com  = (w[0] == k_sym(COM));
        is_skp  = (w[1] == k_sym(SKP)) && (w[2] == k_sym(SKP));
        ts1_ids = 1'b1;
        ts2_ids = 1'b1;
        for (int i = 6; i < WIN_DEPTH; i++) begin
            ts1_ids = ts1_ids && (w[i] == d_sym(TS1ID));
            ts2_ids = ts2_ids && (w[i] == d_sym(TS2ID));
        end
        if (is_com && is_skp) begin
            result = OS_SKP;
        end else if (is_com && ts1_ids) begin
            result = OS_TS1;
        end else if (is_com && ts2_ids) begin
            result = OS_TS2;
        end else begin
            result = OS_NONE;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/modport_rcvr_side_os_window.sv
`default_nettype none
// ============================================================================
// Module      : os_window
// Description : 16-symbol sliding window over the MAC symbol stream plus the
//               ordered-set classifier. Classifies both the registered window
//               (current view) and the window that the next shift would
//               produce (used to fire detection events on the capturing edge).
// Ports       : clk, reset_n      - clock, async active-low reset
//               i_shift_en        - shift i_sym into the window this edge
//               i_flush           - clear the window (wins over shift)
//               i_sym             - incoming {k, data} symbol
//               o_os_type         - class of the registered window
//               o_next_os_type    - class of the window after a shift
//               o_q1, o_q2        - registered link/lane entries ({k, data})
//               o_next_fields     - TS payload bytes of the shifted window
// Revision    : 1.0 - initial release
// ============================================================================
module os_window
    import ozphy_pkg::*;
#(
    parameter int DEPTH = 16
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_shift_en,
    input  logic             i_flush,
    input  logic [8:0]       i_sym,
    output os_type_t         o_os_type,
    output os_type_t         o_next_os_type,
    output logic [8:0]       o_q1,
    output logic [8:0]       o_q2,
    output ts_fields_t       o_next_fields
);

    logic [DEPTH-1:0][SYM_W-1:0] r_q;
    logic [DEPTH-1:0][SYM_W-1:0] w_next;

    // Oldest entry sits at index 0; new symbols enter at the top.
    always_comb begin
        w_next = r_q;
        for (int i = 0; i < DEPTH - 1; i++) begin
            w_next[i] = r_q[i+1];
        end
        w_next[DEPTH-1] = i_sym;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (i_flush) begin
            r_q <= '0;
        end else if (i_shift_en) begin
            r_q <= w_next;
        end
    end

    assign o_os_type      = classify(r_q);
    assign o_next_os_type = classify(w_next);
    assign o_q1           = r_q[1];
    assign o_q2           = r_q[2];

    always_comb begin
        o_next_fields       = '0;
        o_next_fields.linkn = w_next[1][7:0];
        o_next_fields.lanen = w_next[2][7:0];
        o_next_fields.nfts  = w_next[3][7:0];
        o_next_fields.dri   = w_next[4][7:0];
        o_next_fields.tc    = w_next[5][7:0];
    end

endmodule
`default_nettype wire

// File: rtl/modport_rcvr_side.sv
`default_nettype none
// ============================================================================
// Module      : modport_rcvr_side
// Description : Receive-side monitor of the MAC-to-PHY lane. Classifies a
//               16-symbol window as SKP/TS1/TS2/none, captures TS payload
//               fields, counts consecutive TS1/TS2 sets, raises the LTSSM
//               configuration handshake flags and counts idle data symbols.
// Ports       : clk, reset_n            - clock, async active-low reset
//               txdata, txdatak, en_n   - symbol stream from MAC (en_n low =
//                                         valid)
//               curr_ltssm_state        - current LTSSM state
//               os_type                 - class of the current window
//               ts1_ctr, ts2_ctr        - consecutive TS1 / TS2 counts
//               ts1_* / ts2_*           - fields of the last TS1 / TS2
//               link_proposed, lane_proposed, config_complete - handshake
//               idle_ctr                - consecutive idle data symbols
// Revision    : 1.0 - initial release
// ============================================================================
module modport_rcvr_side
    import ozphy_pkg::*;
#(
    parameter int MAX_TS_LEN = 16,
    parameter int CTR_W      = 16
)
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         txdata,
    input  logic               txdatak,
    input  logic               en_n,
    input  ltssm_state_t       curr_ltssm_state,
    output os_type_t           os_type,
    output logic [CTR_W-1:0]   ts1_ctr,
    output logic [CTR_W-1:0]   ts2_ctr,
    output logic [7:0]         ts1_linkn,
    output logic [7:0]         ts1_lanen,
    output logic [7:0]         ts1_nfts,
    output logic [7:0]         ts1_dri,
    output logic [7:0]         ts1_tc,
    output logic [7:0]         ts2_linkn,
    output logic [7:0]         ts2_lanen,
    output logic [7:0]         ts2_nfts,
    output logic [7:0]         ts2_dri,
    output logic [7:0]         ts2_tc,
    output logic               link_proposed,
    output logic               lane_proposed,
    output logic               config_complete,
    output logic [CTR_W-1:0]   idle_ctr
);

    localparam logic [CTR_W-1:0] c_ctr_one = {{(CTR_W-1){1'b0}}, 1'b1};

    ltssm_state_t       r_state;
    logic [CTR_W-1:0]   r_ts1_ctr;
    logic [CTR_W-1:0]   r_ts2_ctr;
    logic [CTR_W-1:0]   r_idle_ctr;
    ts_fields_t         r_ts1_f;
    ts_fields_t         r_ts2_f;

    logic               w_state_chg;
    logic               w_shift_en;
    logic               w_ts1_evt;
    logic               w_ts2_evt;
    logic               w_idle_state;
    os_type_t           w_os_type;
    os_type_t           w_next_os_type;
    logic [8:0]         w_q1;
    logic [8:0]         w_q2;
    ts_fields_t         w_next_fields;

    // A state change flushes the window and drops the incoming symbol, so a
    // detection coinciding with it never counts.
    assign w_state_chg  = (curr_ltssm_state != r_state);
    assign w_shift_en   = !en_n && !w_state_chg;
    assign w_ts1_evt    = w_shift_en && (w_next_os_type == OS_TS1);
    assign w_ts2_evt    = w_shift_en && (w_next_os_type == OS_TS2);
    assign w_idle_state = (curr_ltssm_state == CONFIG_IDLE) ||
                          (curr_ltssm_state == L0);

    os_window #(
        .DEPTH          (MAX_TS_LEN)
    ) u_os_window (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_shift_en     (w_shift_en),
        .i_flush        (w_state_chg),
        .i_sym          ({txdatak, txdata}),
        .o_os_type      (w_os_type),
        .o_next_os_type (w_next_os_type),
        .o_q1           (w_q1),
        .o_q2           (w_q2),
        .o_next_fields  (w_next_fields)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= DETECT_QUIET;
        end else begin
            r_state <= curr_ltssm_state;
        end
    end

    // Consecutive TS counters: a set of one kind breaks the run of the other.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ts1_ctr <= '0;
            r_ts2_ctr <= '0;
        end else if (w_state_chg) begin
            r_ts1_ctr <= '0;
            r_ts2_ctr <= '0;
        end else if (w_ts1_evt) begin
            if (r_ts1_ctr != '1) begin
                r_ts1_ctr <= r_ts1_ctr + c_ctr_one;
            end
            r_ts2_ctr <= '0;
        end else if (w_ts2_evt) begin
            if (r_ts2_ctr != '1) begin
                r_ts2_ctr <= r_ts2_ctr + c_ctr_one;
            end
            r_ts1_ctr <= '0;
        end
    end

    // Field registers survive state changes; only reset clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ts1_f <= '0;
            r_ts2_f <= '0;
        end else begin
            if (w_ts1_evt) begin
                r_ts1_f <= w_next_fields;
            end
            if (w_ts2_evt) begin
                r_ts2_f <= w_next_fields;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_ctr <= '0;
        end else if (w_state_chg || !w_idle_state) begin
            r_idle_ctr <= '0;
        end else if (!en_n) begin
            if (!txdatak && (txdata == IDLE_DATA)) begin
                if (r_idle_ctr != '1) begin
                    r_idle_ctr <= r_idle_ctr + c_ctr_one;
                end
            end else begin
                r_idle_ctr <= '0;
            end
        end
    end

    assign os_type   = w_os_type;
    assign ts1_ctr   = r_ts1_ctr;
    assign ts2_ctr   = r_ts2_ctr;
    assign idle_ctr  = r_idle_ctr;

    assign ts1_linkn = r_ts1_f.linkn;
    assign ts1_lanen = r_ts1_f.lanen;
    assign ts1_nfts  = r_ts1_f.nfts;
    assign ts1_dri   = r_ts1_f.dri;
    assign ts1_tc    = r_ts1_f.tc;
    assign ts2_linkn = r_ts2_f.linkn;
    assign ts2_lanen = r_ts2_f.lanen;
    assign ts2_nfts  = r_ts2_f.nfts;
    assign ts2_dri   = r_ts2_f.dri;
    assign ts2_tc    = r_ts2_f.tc;

    // PAD only matches as a K symbol; a data byte of F7 is a real number.
    assign link_proposed   = (w_os_type == OS_TS1) && (w_q1 != k_sym(PAD)) &&
                             (curr_ltssm_state == CONFIG_LINKWIDTH_START);
    assign lane_proposed   = (w_os_type == OS_TS1) && (w_q2 != k_sym(PAD)) &&
                             (curr_ltssm_state == CONFIG_LINKWIDTH_ACCEPT);
    assign config_complete = (w_os_type == OS_TS2) && (w_q1 != k_sym(PAD)) &&
                             (w_q2 != k_sym(PAD)) &&
                             (curr_ltssm_state == CONFIG_LANENUM_ACCEPT);

endmodule
`default_nettype wire

// File: tb/tb_modport_rcvr_side.sv
`default_nettype none
// ============================================================================
// Module      : tb_modport_rcvr_side
// Description : Self-checking bench for modport_rcvr_side. A table of whole
//               ordered-set transactions with expected results, followed by
//               hand-written sequences for holding, SKP interleave, state
//               change on the detection edge, idle counting and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modport_rcvr_side;
    import ozphy_pkg::*;

    localparam int CTR_W = 16;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [7:0]         txdata;
    logic               txdatak;
    logic               en_n;
    ltssm_state_t       curr;
    os_type_t           os_type;
    logic [CTR_W-1:0]   ts1_ctr, ts2_ctr, idle_ctr;
    logic [7:0]         ts1_linkn, ts1_lanen, ts1_nfts, ts1_dri, ts1_tc;
    logic [7:0]         ts2_linkn, ts2_lanen, ts2_nfts, ts2_dri, ts2_tc;
    logic               link_proposed, lane_proposed, config_complete;

    modport_rcvr_side #(
        .MAX_TS_LEN       (16),
        .CTR_W            (CTR_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .txdata           (txdata),
        .txdatak          (txdatak),
        .en_n             (en_n),
        .curr_ltssm_state (curr),
        .os_type          (os_type),
        .ts1_ctr          (ts1_ctr),
        .ts2_ctr          (ts2_ctr),
        .ts1_linkn        (ts1_linkn),
        .ts1_lanen        (ts1_lanen),
        .ts1_nfts         (ts1_nfts),
        .ts1_dri          (ts1_dri),
        .ts1_tc           (ts1_tc),
        .ts2_linkn        (ts2_linkn),
        .ts2_lanen        (ts2_lanen),
        .ts2_nfts         (ts2_nfts),
        .ts2_dri          (ts2_dri),
        .ts2_tc           (ts2_tc),
        .link_proposed    (link_proposed),
        .lane_proposed    (lane_proposed),
        .config_complete  (config_complete),
        .idle_ctr         (idle_ctr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] seq [16];

    typedef struct {
        ltssm_state_t st;
        bit           ts2;
        logic [7:0]   link, lane, nfts, dri, tc;
        bit           gaps;
        os_type_t     e_os;
        int           e_c1, e_c2;
        bit           e_lk, e_ln, e_cc;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [8:0] s);
        en_n = 1'b0;
        {txdatak, txdata} = s;
        tick();
        en_n = 1'b1;
    endtask

    task automatic gap();
        en_n    = 1'b1;
        txdata  = 8'($urandom);
        txdatak = 1'($urandom);
        tick();
    endtask

    task automatic set_state(input ltssm_state_t s);
        curr = s;
        en_n = 1'b1;
        tick();
    endtask

    function automatic logic [8:0] fld(input logic [7:0] v);
        return (v == PAD) ? {1'b1, PAD} : {1'b0, v};
    endfunction

    task automatic build_os(input bit is_ts2, input logic [7:0] link, input logic [7:0] lane,
                            input logic [7:0] nfts, input logic [7:0] dri, input logic [7:0] tc);
        seq[0] = {1'b1, COM};
        seq[1] = fld(link);
        seq[2] = fld(lane);
        seq[3] = {1'b0, nfts};
        seq[4] = {1'b0, dri};
        seq[5] = {1'b0, tc};
        for (int i = 6; i < 16; i++) begin
            seq[i] = {1'b0, is_ts2 ? TS2ID : TS1ID};
        end
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            send_sym(seq[i]);
            if (gaps && (i == 3 || i == 9) && i != hi) begin
                gap();
            end
        end
    endtask

    logic [39:0] e_t1, e_t2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        en_n    = 1'b1;
        txdata  = 8'h00;
        txdatak = 1'b0;
        curr    = DETECT_QUIET;
        e_t1    = '0;
        e_t2    = '0;
        tick();
        tick();

        // Reset state
        chk("rst_os_type", os_type, OS_NONE);
        chk("rst_ts1_ctr", ts1_ctr, 0);
        chk("rst_ts2_ctr", ts2_ctr, 0);
        chk("rst_idle_ctr", idle_ctr, 0);
        chk("rst_ts1_fields", {ts1_linkn, ts1_lanen, ts1_nfts, ts1_dri, ts1_tc}, 0);
        chk("rst_ts2_fields", {ts2_linkn, ts2_lanen, ts2_nfts, ts2_dri, ts2_tc}, 0);
        chk("rst_flags", {link_proposed, lane_proposed, config_complete}, 0);
        reset_n = 1'b1;
        tick();

        // Transaction table
        tbl[0] = '{CONFIG_LINKWIDTH_START, 1'b0, 8'h01, 8'hF7, 8'h20, 8'h02, 8'h00, 1'b0,
                   OS_TS1, 1, 0, 1'b1, 1'b0, 1'b0};
        for (int i = 1; i <= 8; i++) begin
            tbl[i] = '{CONFIG_LINKWIDTH_ACCEPT, 1'b0, 8'h01, 8'h00, 8'h20, 8'h02, 8'h00,
                       bit'(i % 2), OS_TS1, i, 0, 1'b0, 1'b1, 1'b0};
        end
        tbl[9]  = '{CONFIG_LINKWIDTH_ACCEPT, 1'b1, 8'h01, 8'h00, 8'h20, 8'h02, 8'h00, 1'b0,
                    OS_TS2, 0, 1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{CONFIG_LANENUM_ACCEPT, 1'b1, 8'h01, 8'h00, 8'h18, 8'h02, 8'h04, 1'b1,
                    OS_TS2, 0, 1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{CONFIG_LANENUM_ACCEPT, 1'b1, 8'hF7, 8'h00, 8'h18, 8'h02, 8'h04, 1'b0,
                    OS_TS2, 0, 2, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{CONFIG_LANENUM_ACCEPT, 1'b0, 8'h05, 8'h06, 8'h30, 8'h04, 8'h01, 1'b0,
                    OS_TS1, 1, 0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{CONFIG_LINKWIDTH_START, 1'b0, 8'hF7, 8'hF7, 8'h10, 8'h02, 8'h00, 1'b0,
                    OS_TS1, 1, 0, 1'b0, 1'b0, 1'b0};

        for (int r = 0; r < 14; r++) begin
            if (tbl[r].st != curr) set_state(tbl[r].st);
            build_os(tbl[r].ts2, tbl[r].link, tbl[r].lane, tbl[r].nfts, tbl[r].dri, tbl[r].tc);
            send_range(0, 15, tbl[r].gaps);
            if (tbl[r].ts2) e_t2 = {tbl[r].link, tbl[r].lane, tbl[r].nfts, tbl[r].dri, tbl[r].tc};
            else            e_t1 = {tbl[r].link, tbl[r].lane, tbl[r].nfts, tbl[r].dri, tbl[r].tc};
            chk($sformatf("row%0d_os_type", r), os_type, tbl[r].e_os);
            chk($sformatf("row%0d_ts1_ctr", r), ts1_ctr, tbl[r].e_c1);
            chk($sformatf("row%0d_ts2_ctr", r), ts2_ctr, tbl[r].e_c2);
            chk($sformatf("row%0d_link_proposed", r), link_proposed, tbl[r].e_lk);
            chk($sformatf("row%0d_lane_proposed", r), lane_proposed, tbl[r].e_ln);
            chk($sformatf("row%0d_config_complete", r), config_complete, tbl[r].e_cc);
            chk($sformatf("row%0d_ts1_fields", r),
                {ts1_linkn, ts1_lanen, ts1_nfts, ts1_dri, ts1_tc}, e_t1);
            chk($sformatf("row%0d_ts2_fields", r),
                {ts2_linkn, ts2_lanen, ts2_nfts, ts2_dri, ts2_tc}, e_t2);
        end

        // Held window does not re-count; flag drops on next valid symbol
        build_os(1'b0, 8'h01, 8'hF7, 8'h20, 8'h02, 8'h00);
        send_range(0, 15, 1'b0);
        chk("hold_ts1_ctr_a", ts1_ctr, 2);
        chk("hold_link_p_a", link_proposed, 1);
        gap();
        gap();
        chk("hold_ts1_ctr_b", ts1_ctr, 2);
        chk("hold_link_p_b", link_proposed, 1);
        send_sym({1'b0, 8'h00});
        chk("drop_link_p", link_proposed, 0);
        chk("drop_os_type", os_type, OS_NONE);
        chk("drop_ts1_ctr", ts1_ctr, 2);
        chk("drop_idle_ctr", idle_ctr, 0);

        // SKP ordered set between TS1 sets
        send_range(0, 15, 1'b0);
        chk("skp_pre_ts1_ctr", ts1_ctr, 3);
        send_sym({1'b1, COM});
        send_sym({1'b1, SKP});
        send_sym({1'b1, SKP});
        send_sym({1'b1, SKP});
        send_range(0, 11, 1'b0);
        chk("skp_os_type", os_type, OS_SKP);
        chk("skp_ts1_ctr", ts1_ctr, 3);
        chk("skp_link_p", link_proposed, 0);
        send_range(12, 15, 1'b0);
        chk("skp_post_os_type", os_type, OS_TS1);
        chk("skp_post_ts1_ctr", ts1_ctr, 4);

        // State change on the detection edge: flush wins, fields hold
        build_os(1'b0, 8'h09, 8'h03, 8'h40, 8'h02, 8'h00);
        send_range(0, 14, 1'b0);
        curr = CONFIG_LINKWIDTH_ACCEPT;
        send_sym(seq[15]);
        chk("chg_ts1_ctr", ts1_ctr, 0);
        chk("chg_os_type", os_type, OS_NONE);
        chk("chg_lane_p", lane_proposed, 0);
        chk("chg_ts1_linkn_held", ts1_linkn, 8'h01);
        send_range(0, 15, 1'b0);
        chk("chg_post_ts1_ctr", ts1_ctr, 1);
        chk("chg_post_lane_p", lane_proposed, 1);
        chk("chg_post_ts1_fields", {ts1_linkn, ts1_lanen, ts1_nfts, ts1_dri, ts1_tc},
            40'h09_03_40_02_00);

        // Idle symbol counting
        set_state(CONFIG_IDLE);
        chk("idle_chg_ts1_ctr", ts1_ctr, 0);
        chk("idle_chg_os_type", os_type, OS_NONE);
        for (int i = 1; i <= 20; i++) begin
            send_sym({1'b0, 8'h00});
            if (i % 5 == 0) gap();
            if (i == 10) chk("idle_ctr_10", idle_ctr, 10);
        end
        chk("idle_ctr_20", idle_ctr, 20);
        send_sym({1'b0, 8'h01});
        chk("idle_nonzero_clear", idle_ctr, 0);
        repeat (3) send_sym({1'b0, 8'h00});
        chk("idle_ctr_3", idle_ctr, 3);
        send_sym({1'b1, 8'h00});
        chk("idle_kzero_clear", idle_ctr, 0);
        repeat (2) send_sym({1'b0, 8'h00});
        chk("idle_ctr_2", idle_ctr, 2);
        curr = L0;
        send_sym({1'b0, 8'h00});
        chk("idle_state_chg_clear", idle_ctr, 0);
        send_sym({1'b0, 8'h00});
        chk("idle_l0_count", idle_ctr, 1);
        set_state(POLLING_ACTIVE);
        send_sym({1'b0, 8'h00});
        chk("idle_other_state", idle_ctr, 0);

        // Reset in the middle of an ordered set
        set_state(CONFIG_LINKWIDTH_START);
        build_os(1'b0, 8'h01, 8'hF7, 8'h20, 8'h02, 8'h00);
        send_range(0, 7, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_os_type", os_type, OS_NONE);
        chk("mid_rst_ctrs", {ts1_ctr, ts2_ctr, idle_ctr}, 0);
        chk("mid_rst_fields",
            {ts1_linkn, ts1_lanen, ts1_nfts, ts1_dri, ts1_tc,
             ts2_linkn, ts2_lanen, ts2_nfts, ts2_dri, ts2_tc}, 0);
        chk("mid_rst_flags", {link_proposed, lane_proposed, config_complete}, 0);
        reset_n = 1'b1;
        tick();
        send_range(8, 15, 1'b0);
        chk("post_rst_partial_os", os_type, OS_NONE);
        chk("post_rst_partial_ctr", ts1_ctr, 0);
        send_range(0, 15, 1'b0);
        chk("post_rst_ts1_ctr", ts1_ctr, 1);
        chk("post_rst_link_p", link_proposed, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
